// File: rtl/systolic_ctrl_3x3.sv
// Sequencer for a 3x3 output-stationary systolic multiply array: holds operands A/B,
// streams skewed rows/columns into the array edges and captures C = A*B.
module systolic_ctrl_3x3 #(
    parameter int unsigned DATA_SIZE = 8,
    localparam int unsigned ResW = 2 * DATA_SIZE + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en_i,
    input  logic                 wr_sel_i,
    input  logic [3:0]           wr_addr_i,
    input  logic [DATA_SIZE-1:0] wr_data_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ResW-1:0]      res0_o,
    output logic [ResW-1:0]      res1_o,
    output logic [ResW-1:0]      res2_o,
    output logic [ResW-1:0]      res3_o,
    output logic [ResW-1:0]      res4_o,
    output logic [ResW-1:0]      res5_o,
    output logic [ResW-1:0]      res6_o,
    output logic [ResW-1:0]      res7_o,
    output logic [ResW-1:0]      res8_o,
    output logic                 arr_reset_o,
    output logic [DATA_SIZE-1:0] arr_a1_o,
    output logic [DATA_SIZE-1:0] arr_a2_o,
    output logic [DATA_SIZE-1:0] arr_a3_o,
    output logic [DATA_SIZE-1:0] arr_b1_o,
    output logic [DATA_SIZE-1:0] arr_b2_o,
    output logic [DATA_SIZE-1:0] arr_b3_o,
    input  logic [ResW-1:0]      arr_c1_i,
    input  logic [ResW-1:0]      arr_c2_i,
    input  logic [ResW-1:0]      arr_c3_i,
    input  logic [ResW-1:0]      arr_c4_i,
    input  logic [ResW-1:0]      arr_c5_i,
    input  logic [ResW-1:0]      arr_c6_i,
    input  logic [ResW-1:0]      arr_c7_i,
    input  logic [ResW-1:0]      arr_c8_i,
    input  logic [ResW-1:0]      arr_c9_i
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StCapture,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic   [2:0]           t_q, t_d;
    logic   [DATA_SIZE-1:0] a_q [9];
    logic   [DATA_SIZE-1:0] b_q [9];
    logic   [ResW-1:0]      res_q [9];
    logic   [ResW-1:0]      c_in [9];
    logic   [DATA_SIZE-1:0] edge_a [3];
    logic   [DATA_SIZE-1:0] edge_b [3];

    assign c_in[0] = arr_c1_i;
    assign c_in[1] = arr_c2_i;
    assign c_in[2] = arr_c3_i;
    assign c_in[3] = arr_c4_i;
    assign c_in[4] = arr_c5_i;
    assign c_in[5] = arr_c6_i;
    assign c_in[6] = arr_c7_i;
    assign c_in[7] = arr_c8_i;
    assign c_in[8] = arr_c9_i;

    // Operand storage deliberately has no reset; contents survive an aborted run.
    always_ff @(posedge clk) begin
        if (wr_en_i && (state_q == StIdle) && (wr_addr_i <= 4'd8)) begin
            if (wr_sel_i) begin
                b_q[wr_addr_i] <= wr_data_i;
            end else begin
                a_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            t_q     <= 3'd0;
            for (int i = 0; i < 9; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            if (state_q == StCapture) begin
                for (int i = 0; i < 9; i++) begin
                    res_q[i] <= c_in[i];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StFeed;
                t_d     = 3'd0;
            end
            StFeed: begin
                t_d = t_q + 3'd1;
                if (t_q == 3'd6) begin
                    state_d = StCapture;
                end
            end
            StCapture: state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Row i carries A[i][k] and column i carries B[k][i] when t == i + k.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            edge_a[i] = '0;
            edge_b[i] = '0;
        end
        if (state_q == StFeed) begin
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < 3; k++) begin
                    if (int'(t_q) == i + k) begin
                        edge_a[i] = a_q[3*i+k];
                        edge_b[i] = b_q[3*k+i];
                    end
                end
            end
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign arr_reset_o = (state_q == StIdle) || (state_q == StClear);

    assign arr_a1_o = edge_a[0];
    assign arr_a2_o = edge_a[1];
    assign arr_a3_o = edge_a[2];
    assign arr_b1_o = edge_b[0];
    assign arr_b2_o = edge_b[1];
    assign arr_b3_o = edge_b[2];

    assign res0_o = res_q[0];
    assign res1_o = res_q[1];
    assign res2_o = res_q[2];
    assign res3_o = res_q[3];
    assign res4_o = res_q[4];
    assign res5_o = res_q[5];
    assign res6_o = res_q[6];
    assign res7_o = res_q[7];
    assign res8_o = res_q[8];

endmodule

// File: tb/tb_systolic_ctrl_3x3.sv
// Bench for systolic_ctrl_3x3 with a behavioural 3x3 output-stationary array attached.
module tb_systolic_ctrl_3x3;

    typedef logic [8:0][7:0]  mat_t;
    typedef logic [8:0][16:0] resv_t;
    typedef struct packed {
        mat_t  a;
        mat_t  b;
        resv_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [7:0]  wr_data = 8'd0;
    logic        busy, done, arr_reset;
    logic [16:0] res0, res1, res2, res3, res4, res5, res6, res7, res8;
    logic [7:0]  arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3;
    logic [16:0] acc [9];

    int checks = 0;
    int failures = 0;
    mat_t  cur_a, cur_b;
    resv_t sb_q [$];
    vec_t  tab [4];

    always #5 clk = ~clk;

    systolic_ctrl_3x3 #(.DATA_SIZE(8)) dut (
        .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .start_i(start), .busy_o(busy), .done_o(done),
        .res0_o(res0), .res1_o(res1), .res2_o(res2), .res3_o(res3), .res4_o(res4),
        .res5_o(res5), .res6_o(res6), .res7_o(res7), .res8_o(res8),
        .arr_reset_o(arr_reset),
        .arr_a1_o(arr_a1), .arr_a2_o(arr_a2), .arr_a3_o(arr_a3),
        .arr_b1_o(arr_b1), .arr_b2_o(arr_b2), .arr_b3_o(arr_b3),
        .arr_c1_i(acc[0]), .arr_c2_i(acc[1]), .arr_c3_i(acc[2]), .arr_c4_i(acc[3]),
        .arr_c5_i(acc[4]), .arr_c6_i(acc[5]), .arr_c7_i(acc[6]), .arr_c8_i(acc[7]),
        .arr_c9_i(acc[8])
    );

    // Array model: operands move right/down one PE per cycle, each PE accumulates a*b.
    logic [7:0] a_reg [3][3], b_reg [3][3], a_in [3][3], b_in [3][3];
    always_comb begin
        a_in[0][0] = arr_a1; a_in[1][0] = arr_a2; a_in[2][0] = arr_a3;
        b_in[0][0] = arr_b1; b_in[0][1] = arr_b2; b_in[0][2] = arr_b3;
        for (int i = 0; i < 3; i++) begin
            for (int j = 1; j < 3; j++) a_in[i][j] = a_reg[i][j-1];
        end
        for (int i = 1; i < 3; i++) begin
            for (int j = 0; j < 3; j++) b_in[i][j] = b_reg[i-1][j];
        end
        a_in[0][0] = arr_a1;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (arr_reset) begin
                    a_reg[i][j] <= 8'd0;
                    b_reg[i][j] <= 8'd0;
                    acc[3*i+j]  <= 17'd0;
                end else begin
                    a_reg[i][j] <= a_in[i][j];
                    b_reg[i][j] <= b_in[i][j];
                    acc[3*i+j]  <= acc[3*i+j] + 17'(a_in[i][j]) * 17'(b_in[i][j]);
                end
            end
        end
    end

    function automatic resv_t matmul(input mat_t a, input mat_t b);
        resv_t r;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                r[3*i+j] = 17'd0;
                for (int k = 0; k < 3; k++) r[3*i+j] += 17'(a[3*i+k]) * 17'(b[3*k+j]);
            end
        end
        return r;
    endfunction

    // Expected edge vector {a1,a2,a3,b1,b2,b3} for run cycle n (FEED is n = 2..8, t = n-2).
    function automatic logic [47:0] exp_edges(input int n);
        logic [7:0] ea [3];
        logic [7:0] eb [3];
        for (int i = 0; i < 3; i++) begin
            ea[i] = 8'd0;
            eb[i] = 8'd0;
            if (n >= 2 && n <= 8) begin
                if (n - 2 - i >= 0 && n - 2 - i <= 2) begin
                    ea[i] = cur_a[3*i + (n-2-i)];
                    eb[i] = cur_b[3*(n-2-i) + i];
                end
            end
        end
        return {ea[0], ea[1], ea[2], eb[0], eb[1], eb[2]};
    endfunction

    function automatic resv_t got_res();
        return {res8, res7, res6, res5, res4, res3, res2, res1, res0};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit sel, input logic [3:0] addr, input logic [7:0] data,
                      input bit record);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
        if (record && addr <= 4'd8) begin
            if (sel) cur_b[addr] = data;
            else cur_a[addr] = data;
        end
    endtask

    task automatic load(input mat_t a, input mat_t b);
        for (int k = 0; k < 9; k++) wr(1'b0, 4'(k), a[k], 1'b1);
        for (int k = 0; k < 9; k++) wr(1'b1, 4'(k), b[k], 1'b1);
    endtask

    // Starts from an IDLE cycle; returns in the first IDLE cycle after DONE.
    task automatic run_job(input string tag, input resv_t expv, input bit disturb,
                           input bit pre_wr, input logic [3:0] pre_addr,
                           input logic [7:0] pre_data);
        int n;
        resv_t e;
        start = 1'b1;
        if (pre_wr) begin
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = pre_addr; wr_data = pre_data;
            cur_b[pre_addr] = pre_data;
        end
        sb_q.push_back(expv);
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        n = 1;
        while (n <= 12) begin
            chk({tag, "_cyc"}, {13'd0, busy, arr_reset, done, arr_a1, arr_a2, arr_a3,
                                 arr_b1, arr_b2, arr_b3},
                {13'd0, 1'b1, n == 1, n == 10, exp_edges(n)});
            if (done) break;
            if (disturb && n >= 3 && n <= 5) begin
                wr_en = 1'b1; wr_sel = n[0]; wr_addr = 4'(n); wr_data = 8'hAA; start = 1'b1;
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
            tick();
            n++;
        end
        wr_en = 1'b0; start = 1'b0;
        chk({tag, "_latency"}, 64'(n), 64'd10);
        if (done && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int k = 0; k < 9; k++) chk($sformatf("%s_res%0d", tag, k), 64'(got_res()[k]),
                                            64'(e[k]));
        end else begin
            chk({tag, "_no_done"}, 64'(done), 64'd1);
        end
        tick();
        chk({tag, "_idle"}, {13'd0, busy, arr_reset, done, arr_a1, arr_a2, arr_a3, arr_b1,
                             arr_b2, arr_b3}, {13'd0, 3'b010, 48'd0});
    endtask

    initial begin
        int e1 [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
        mat_t b0;
        for (int k = 0; k < 9; k++) begin
            tab[0].a[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
            tab[0].b[k] = 8'(k + 1);
            tab[0].exp[k] = 17'(k + 1);
            tab[1].a[k] = 8'(k + 1);
            tab[1].b[k] = 8'(9 - k);
            tab[1].exp[k] = 17'(e1[k]);
            tab[2].a[k] = 8'd255;
            tab[2].b[k] = 8'd255;
            tab[2].exp[k] = 17'd64003;
            tab[3].a[k] = 8'($urandom_range(0, 255));
            tab[3].b[k] = 8'($urandom_range(0, 255));
        end
        tab[3].exp = matmul(tab[3].a, tab[3].b);

        repeat (3) tick();
        reset = 1'b0;
        chk("rst_ctrl", {13'd0, busy, arr_reset, done, arr_a1, arr_a2, arr_a3, arr_b1, arr_b2,
                         arr_b3}, {13'd0, 3'b010, 48'd0});
        chk("rst_res", 64'(got_res() != '0), 64'd0);

        for (int v = 0; v < 4; v++) begin
            if (v == 0) begin
                // B[2][2] is committed by a write in the same cycle as start.
                b0 = tab[0].b;
                b0[8] = 8'd0;
                load(tab[0].a, b0);
                run_job("ident", tab[0].exp, 1'b0, 1'b1, 4'd8, 8'd9);
            end else begin
                load(tab[v].a, tab[v].b);
                run_job($sformatf("vec%0d", v), tab[v].exp, 1'b0, 1'b0, 4'd0, 8'd0);
            end
        end

        load(tab[1].a, tab[1].b);
        wr(1'b0, 4'd12, 8'hFF, 1'b0);
        wr(1'b1, 4'd12, 8'hFF, 1'b0);
        run_job("disturb", tab[1].exp, 1'b1, 1'b0, 4'd0, 8'd0);
        run_job("b2b", tab[1].exp, 1'b0, 1'b0, 4'd0, 8'd0);

        load(tab[2].a, tab[2].b);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_ctrl", {13'd0, busy, arr_reset, done, arr_a1, arr_a2, arr_a3, arr_b1,
                           arr_b2, arr_b3}, {13'd0, 3'b010, 48'd0});
        chk("abort_res", 64'(got_res() != '0), 64'd0);
        run_job("after_abort", tab[2].exp, 1'b0, 1'b0, 4'd0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl_3x3.md
# systolic_ctrl_3x3

Sequencer for the 3x3 output-stationary systolic multiply array. It holds operand matrices A and B, written by a host, and clears the array's accumulators. It then streams skewed rows of A and columns of B into the array edges, captures the nine products C = A·B into result registers and signals completion. It sits between the host register interface and the array instance.

## Interface
- DATA_SIZE, 8, operand width; result width is 2*DATA_SIZE+1.
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- wr_en  input  1  host write strobe for operand storage.
- wr_sel  input  1  0 = matrix A, 1 = matrix B.
- wr_addr  input  4  element index 0..8, row-major (addr = 3*row+col).
- wr_data  input  DATA_SIZE  unsigned operand.
- start  input  1  begin multiply (sampled only in IDLE).
- busy  output  1  high from the cycle after start acceptance through the DONE cycle.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- res0..res8  output  2*DATA_SIZE+1 each  captured C[i][j] at index 3*i+j.
- arr_reset  output  1  array accumulator/pipeline clear.
- arr_a1..arr_a3  output  DATA_SIZE  row inputs of the array (row 0..2).
- arr_b1..arr_b3  output  DATA_SIZE  column inputs of the array (col 0..2).
- arr_c1..arr_c9  input  2*DATA_SIZE+1  array accumulators, arr_c(3i+j+1) = PE(i,j).

## Operation
- Storage: 9 A regs, 9 B regs, written on wr_en only when state is IDLE. A write with wr_addr > 8 is ignored. Storage is not cleared by reset.
- FSM states: IDLE -> CLEAR -> FEED -> CAPTURE -> DONE -> IDLE.
  - IDLE: arr_reset=1. On start=1 go to CLEAR.
  - CLEAR: arr_reset=1, one cycle; go to FEED and set t=0.
  - FEED: arr_reset=0, t counts 0..6. Stay 7 cycles, then go to CAPTURE.
  - CAPTURE: arr_reset=0. arr_c1..9 are sampled into res0..8 at the end of this cycle. Go to DONE.
  - DONE: done=1, arr_reset=0; go to IDLE.
- Skew during FEED, applied combinationally from the registered state and t:
  - arr_a(i+1) = A[i][t-i] if 0 ≤ t-i ≤ 2, else 0.
  - arr_b(j+1) = B[t-j][j] if 0 ≤ t-j ≤ 2, else 0.
  - All arr_a/arr_b are 0 outside FEED.
- PE(i,j) therefore sees A[i][k] with B[k][j] at t = i+j+k. Zero padding adds nothing to the accumulators.
- Arithmetic: unsigned; results are the array's values modulo 2^(2*DATA_SIZE+1), with no saturation.
- start in any state other than IDLE is ignored. start together with wr_en in IDLE: the write commits at the same edge and is used by that run.
- Reset mid-operation: next state is IDLE; busy=0, done=0, res0..8=0, arr_reset=1; the run is abandoned.

## Timing
- Reset values: busy=0, done=0, res0..8=0, arr_reset=1, arr_a*/arr_b*=0, state=IDLE.
- start sampled high at the edge ending cycle S:
  - CLEAR is cycle S+1.
  - FEED is cycles S+2..S+8, with t=0 at S+2.
  - CAPTURE is cycle S+9.
  - DONE is cycle S+10.
- busy=1 in cycles S+1..S+10. done=1 in cycle S+10 only. Start-to-done latency is 10 cycles.
- The last accumulation (PE(2,2), k=2) happens at the edge ending S+8, so arr_c9 is final in S+9.
- res0..8 update at the edge ending S+9 and hold until the next capture or reset.
- Back-to-back: start in cycle S+11 (first IDLE cycle) is accepted. Throughput is 1 result set per 11 cycles.

## Test plan
- Identity check: A = identity, B = 1..9, start -> done exactly 10 cycles after start; res0..8 = 1..9; busy high for 10 cycles.
- General values: A = 1..9, B = 9..1 -> res = 30,24,18,84,69,54,138,114,90. Also check the arr_a/arr_b skew sequence cycle by cycle (e.g. arr_a3 = A[2][0]=7 first at t=2).
- Overflow: all A, B = 255 -> every res = 195075 mod 131072 = 64003.
- Protocol: wr_en and start during busy, and wr_addr=12 in IDLE -> storage unchanged, no restart, result identical to the undisturbed run. Start on the cycle after done -> second run completes 10 cycles later.
- Reset at S+5 -> next cycle busy=0, arr_reset=1, res=0. A following run returns correct results with no residue from the aborted run.
